// File: rtl/sobel_pkg.sv
// Shared widths, pipeline latency and arithmetic helpers for the Sobel edge stage.
package sobel_pkg;

  localparam int LAT    = 3;
  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 12;

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, v});
  endfunction

  function automatic logic [PIX_W-1:0] saturate(input logic [MAG_W-1:0] mag, input int shift);
    logic [MAG_W-1:0] s;
    s = mag >> shift;
    return (s > MAG_W'(255)) ? {PIX_W{1'b1}} : s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel store: single clock, read-first, registered read, no reset.
module sobel_line_buf #(
  parameter int DEPTH = 1920,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/sobel_edge.sv
// Sobel gradient magnitude over a luma stream, 3-cycle fixed latency, controls delayed alongside.
// Define SOBEL_BINARIZE_EN to add thr_i and emit 8'hFF/8'h00 against that threshold.
module sobel_edge
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH = 1920,
  parameter int SHIFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] y_i,
  input  logic             dv_i,
  input  logic             hs_i,
  input  logic             vs_i,
`ifdef SOBEL_BINARIZE_EN
  input  logic [PIX_W-1:0] thr_i,
`endif
  output logic [PIX_W-1:0] edge_o,
  output logic             dv_o,
  output logic             hs_o,
  output logic             vs_o
);

  localparam int CW = $clog2(MAX_WIDTH + 1);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic             dv_q, vs_q;
  logic [CW-1:0]    col_cnt, col_cur;
  logic [1:0]       row_cnt, row_cur;
  logic             in_rng;
  logic [AW-1:0]    addr;
  logic [PIX_W-1:0] rd0, rd1;

  logic             v1, ok1, dv1, hs1, vs1;
  logic [PIX_W-1:0] y1;
  logic [AW-1:0]    addr1;
  logic [PIX_W-1:0] p [3][3];
  logic             ok2, dv2, hs2, vs2;

  logic signed [GRAD_W-1:0] gx, gy;
  logic [GRAD_W-1:0]        ax, ay;
  logic [MAG_W-1:0]         mag;
  logic [PIX_W-1:0]         sat, edge_n;

  // A rising dv/vs edge applies to the pixel on that same cycle.
  always_comb begin
    col_cur = (dv_i && !dv_q) ? '0 : col_cnt;
    row_cur = (vs_i && !vs_q) ? 2'd0 : row_cnt;
    in_rng  = dv_i && (col_cur < CW'(MAX_WIDTH));
    addr    = col_cur[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q    <= 1'b0;
      vs_q    <= 1'b0;
      col_cnt <= '0;
      row_cnt <= 2'd0;
    end else begin
      dv_q <= dv_i;
      vs_q <= vs_i;
      if (dv_i) col_cnt <= in_rng ? col_cur + CW'(1) : CW'(MAX_WIDTH);
      if (vs_i && !vs_q)                          row_cnt <= 2'd0;
      else if (!dv_i && dv_q && row_cnt != 2'd2)  row_cnt <= row_cnt + 2'd1;
    end
  end

  sobel_line_buf #(.DEPTH(MAX_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .clk(clk), .wr_en(in_rng), .wr_addr(addr), .wr_dat(y_i),
    .rd_en(in_rng), .rd_addr(addr), .rd_dat(rd0)
  );

  // lb1 takes lb0's old value one cycle later, once the registered read lands.
  sobel_line_buf #(.DEPTH(MAX_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .clk(clk), .wr_en(v1), .wr_addr(addr1), .wr_dat(rd0),
    .rd_en(in_rng), .rd_addr(addr), .rd_dat(rd1)
  );

  always_comb begin
    gx = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
       - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
    gy = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
       - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
    ax  = gx[GRAD_W-1] ? GRAD_W'(-gx) : GRAD_W'(gx);
    ay  = gy[GRAD_W-1] ? GRAD_W'(-gy) : GRAD_W'(gy);
    mag = MAG_W'(ax) + MAG_W'(ay);
    sat = saturate(mag, SHIFT);
`ifdef SOBEL_BINARIZE_EN
    edge_n = (ok2 && (sat >= thr_i)) ? {PIX_W{1'b1}} : '0;
`else
    edge_n = ok2 ? sat : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1     <= 1'b0;
      ok1    <= 1'b0;
      y1     <= '0;
      addr1  <= '0;
      dv1    <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      p      <= '{default: '0};
      ok2    <= 1'b0;
      dv2    <= 1'b0;
      hs2    <= 1'b0;
      vs2    <= 1'b0;
      edge_o <= '0;
      dv_o   <= 1'b0;
      hs_o   <= 1'b0;
      vs_o   <= 1'b0;
    end else begin
      v1    <= in_rng;
      ok1   <= in_rng && (row_cur == 2'd2) && (col_cur >= CW'(2));
      y1    <= y_i;
      addr1 <= addr;
      dv1   <= dv_i;
      hs1   <= hs_i;
      vs1   <= vs_i;
      if (v1) begin
        for (int r = 0; r < 3; r++) begin
          p[r][0] <= p[r][1];
          p[r][1] <= p[r][2];
        end
        p[0][2] <= rd1;
        p[1][2] <= rd0;
        p[2][2] <= y1;
      end
      ok2    <= ok1;
      dv2    <= dv1;
      hs2    <= hs1;
      vs2    <= vs1;
      edge_o <= edge_n;
      dv_o   <= dv2;
      hs_o   <= hs2;
      vs_o   <= vs2;
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// Directed frames through two sobel_edge instances (SHIFT 0 and 2) checked against an image-level model.
module tb_sobel_edge;

  localparam int MAXW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] y_i = 8'd0;
  logic       dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
`ifdef SOBEL_BINARIZE_EN
  logic [7:0] thr_i = 8'd50;
`endif
  logic [7:0] edge0, edge2;
  logic       dv0, hs0, vs0, dv2, hs2, vs2;

  sobel_edge #(.MAX_WIDTH(MAXW), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
`ifdef SOBEL_BINARIZE_EN
    .thr_i(thr_i),
`endif
    .edge_o(edge0), .dv_o(dv0), .hs_o(hs0), .vs_o(vs0)
  );

  sobel_edge #(.MAX_WIDTH(MAXW), .SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
`ifdef SOBEL_BINARIZE_EN
    .thr_i(thr_i),
`endif
    .edge_o(edge2), .dv_o(dv2), .hs_o(hs2), .vs_o(vs2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int img [8][16];

  // Expected outputs, indexed by the cycle the input was applied.
  bit [7:0] rec_e0 [4096];
  bit [7:0] rec_e2 [4096];
  bit       rec_dv [4096];
  bit       rec_hs [4096];
  bit       rec_vs [4096];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int mag_at(input int r, input int c);
    int gx, gy;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int exp_px(input int r, input int c, input int sh);
    int s;
    if (r < 2 || c < 2 || c >= MAXW) return 0;
    s = mag_at(r, c) >> sh;
    if (s > 255) s = 255;
`ifdef SOBEL_BINARIZE_EN
    return (s >= int'(thr_i)) ? 255 : 0;
`else
    return s;
`endif
  endfunction

  always @(negedge clk) begin
    if (cyc >= 3) begin
      check("edge_s0", int'(edge0), int'(rec_e0[(cyc-3) & 4095]));
      check("edge_s2", int'(edge2), int'(rec_e2[(cyc-3) & 4095]));
      check("dv_o",    int'(dv0),   int'(rec_dv[(cyc-3) & 4095]));
      check("hs_o",    int'(hs0),   int'(rec_hs[(cyc-3) & 4095]));
      check("vs_o",    int'(vs0),   int'(rec_vs[(cyc-3) & 4095]));
      check("dv_o_s2", int'(dv2),   int'(rec_dv[(cyc-3) & 4095]));
      check("hs_o_s2", int'(hs2),   int'(rec_hs[(cyc-3) & 4095]));
      check("vs_o_s2", int'(vs2),   int'(rec_vs[(cyc-3) & 4095]));
    end
  end

  task automatic pix(input int y, input bit dv, input bit hs, input bit vs, input int e0, input int e2);
    @(negedge clk);
    y_i  = 8'(y);
    dv_i = dv;
    hs_i = hs;
    vs_i = vs;
    rec_e0[cyc & 4095] = 8'(e0);
    rec_e2[cyc & 4095] = 8'(e2);
    rec_dv[cyc & 4095] = dv;
    rec_hs[cyc & 4095] = hs;
    rec_vs[cyc & 4095] = vs;
  endtask

  // mode 0: flat 128, 1: vertical step of height amp at col 4, else random
  task automatic line(input int r, input int w, input int mode, input int amp);
    for (int c = 0; c < w; c++) begin
      int y;
      case (mode)
        0:       y = 128;
        1:       y = (c >= 4) ? amp : 0;
        default: y = int'($urandom_range(0, 255));
      endcase
      img[r][c] = y;
      pix(y, 1'b1, 1'b0, 1'b0, exp_px(r, c, 0), exp_px(r, c, 2));
    end
    pix(0, 1'b0, 1'b0, 1'b0, 0, 0);
    pix(0, 1'b0, 1'b1, 1'b0, 0, 0);
    pix(0, 1'b0, 1'b1, 1'b0, 0, 0);
    pix(0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic frame(input int h, input int w, input int mode, input int amp, input bit with_vs);
    if (with_vs) begin
      pix(0, 1'b0, 1'b0, 1'b1, 0, 0);
      pix(0, 1'b0, 1'b0, 1'b1, 0, 0);
      pix(0, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    for (int r = 0; r < h; r++) line(r, w, mode, amp);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pix(0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("rst_edge", int'(edge0), 0);
    check("rst_dv",   int'(dv0),   0);
    rst = 1'b1;

    // Async reset mid-line while a nonzero gradient is on the output.
    frame(3, 8, 1, 200, 1'b1);
    for (int c = 0; c < 8; c++) begin
      img[3][c] = (c >= 4) ? 200 : 0;
      pix(img[3][c], 1'b1, 1'b0, 1'b0, exp_px(3, c, 0), exp_px(3, c, 2));
    end
    #2;
    check("pre_rst_edge_s0", int'(edge0), 255);
    check("pre_rst_edge_s2", int'(edge2), 200);
    check("pre_rst_dv",      int'(dv0),   1);
    rst = 1'b0;
    #1;
    check("async_rst_edge", int'(edge0), 0);
    check("async_rst_dv",   int'(dv0),   0);
    check("async_rst_hs",   int'(hs0),   0);
    check("async_rst_vs",   int'(vs0),   0);
    for (int k = 0; k < 3; k++) begin
      rec_e0[(cyc-k) & 4095] = 8'd0;
      rec_e2[(cyc-k) & 4095] = 8'd0;
      rec_dv[(cyc-k) & 4095] = 1'b0;
    end
    for (int i = 0; i < 3; i++) pix(0, 1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    frame(4, 8, 2, 0, 1'b0);

    frame(6, 8, 0, 0, 1'b1);                 // flat field
    frame(6, 8, 1, 100, 1'b1);               // vertical step
    check("pin_step_mag", mag_at(2, 4), 400);
    check("pin_step_s0",  exp_px(2, 4, 0), 255);
    check("pin_flat_col", exp_px(3, 6, 0), 0);
    frame(6, 8, 2, 0, 1'b1);                 // random, border rows/cols
    frame(4, 10, 2, 0, 1'b1);                // lines longer than MAX_WIDTH
    check("pin_overlong", exp_px(3, 9, 0), 0);
    frame(4, 8, 1, 10, 1'b1);                // weak step, below threshold when binarized
    check("pin_mag_40", mag_at(2, 4), 40);
    frame(4, 8, 1, 20, 1'b1);                // stronger step
    check("pin_mag_80", mag_at(2, 4), 80);

    for (int i = 0; i < 5; i++) pix(0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
